// File: rtl/c17_bist_driver.sv
// BIST pattern driver for a c17 stage: a 5-bit LFSR supplies patterns, and an 8-bit MISR compacts the 2-bit response.
// Latency: DONE rises NUM_PAT+1 edges after START is accepted, or 1 edge after it when NUM_PAT==0.
// Backpressure: none; START is sampled only in IDLE/DONE and is ignored while a run is in progress.
// Ports: CK/RST clock and async active-high reset; START/SEED/NUM_PAT run request;
//        PAT/PAT_VALID registered pattern out; RESP c17 response in; SIG signature; BUSY/DONE status.
module c17_bist_driver #(
    parameter int MISR_W = 8,   // only 8 is supported: the feedback taps are fixed
    parameter int CNT_W  = 6
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic [4:0]        SEED,
    input  logic [CNT_W-1:0]  NUM_PAT,
    output logic [4:0]        PAT,
    output logic              PAT_VALID,
    input  logic [1:0]        RESP,
    output logic [MISR_W-1:0] SIG,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MISR_W-1:0]  misr_q, misr_d;
    logic [4:0]         pat_q, pat_d;
    logic               pat_vld_q, pat_vld_d;

    logic [4:0]         lfsr_next;
    logic [MISR_W-1:0]  misr_next;

    // x^5 + x^3 + 1, maximal length (31 states, never reaches zero)
    assign lfsr_next = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    // Shift with feedback from taps 7,5,4,3, then fold the response into the low bits
    assign misr_next = {misr_q[MISR_W-2:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]}
                     ^ {{(MISR_W-2){1'b0}}, RESP};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    misr_d = '0;
                    if (NUM_PAT != '0) begin
                        // an all-zero seed would lock the LFSR, so substitute 1
                        lfsr_d  = (SEED == 5'd0) ? 5'd1 : SEED;
                        cnt_d   = NUM_PAT;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                misr_d = misr_next;
                lfsr_d = lfsr_next;
                cnt_d  = cnt_q - CNT_W'(1);
                // the last pattern is compacted on this same edge
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // PAT is registered, so it is computed from the state it will accompany
        pat_vld_d = (state_d == ST_RUN);
        pat_d     = (state_d == ST_RUN) ? lfsr_d : 5'd0;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= 5'd1;
            cnt_q     <= '0;
            misr_q    <= '0;
            pat_q     <= 5'd0;
            pat_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            misr_q    <= misr_d;
            pat_q     <= pat_d;
            pat_vld_q <= pat_vld_d;
        end
    end

    assign PAT       = pat_q;
    assign PAT_VALID = pat_vld_q;
    assign SIG       = misr_q;
    assign BUSY      = (state_q == ST_RUN);
    assign DONE      = (state_q == ST_DONE);

endmodule

// File: tb/tb_c17_bist_driver.sv
// Testbench for c17_bist_driver: a c17 model drives RESP, and a reference model predicts every PAT and SIG.
// Latency: checks that DONE rises exactly NUM_PAT+1 edges after START.
// Backpressure: not applicable; it also exercises START, SEED and NUM_PAT changing while a run is in progress.
`timescale 1ns/1ps
module tb_c17_bist_driver;

    localparam int MISR_W = 8;
    localparam int CNT_W  = 6;

    logic              CK = 1'b0;
    logic              RST;
    logic              START;
    logic [4:0]        SEED;
    logic [CNT_W-1:0]  NUM_PAT;
    logic [4:0]        PAT;
    logic              PAT_VALID;
    logic [1:0]        RESP;
    logic [MISR_W-1:0] SIG;
    logic              BUSY;
    logic              DONE;

    int n_checks = 0;
    int n_fail   = 0;

    // pattern monitor
    int          vld_cnt = 0;
    int          dup_cnt = 0;
    logic [31:0] seen    = 32'd0;

    c17_bist_driver #(.MISR_W(MISR_W), .CNT_W(CNT_W)) dut (
        .CK        (CK),
        .RST       (RST),
        .START     (START),
        .SEED      (SEED),
        .NUM_PAT   (NUM_PAT),
        .PAT       (PAT),
        .PAT_VALID (PAT_VALID),
        .RESP      (RESP),
        .SIG       (SIG),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CK = ~CK;

    // ISCAS-85 c17 netlist; pattern bits are {N1,N2,N3,N6,N7}
    function automatic logic [1:0] c17(input logic [4:0] p);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    assign RESP = c17(PAT);

    // Reference: polynomial arithmetic on integers
    function automatic int lfsr_step(input int x);
        return ((x << 1) & 31) | (((x >> 4) ^ (x >> 2)) & 1);
    endfunction

    function automatic int misr_step(input int m, input int r);
        int fb;
        fb = (m >> 7) ^ (m >> 5) ^ (m >> 4) ^ (m >> 3);
        return (((m << 1) & 255) | (fb & 1)) ^ r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge CK) begin
        if (PAT_VALID) begin
            vld_cnt++;
            if (seen[PAT]) dup_cnt++;
            seen[PAT] = 1'b1;
        end
    end

    // One run, starting and ending on a negedge. With disturb set, START/SEED/NUM_PAT are scrambled during RUN.
    task automatic do_run(input logic [4:0] seed, input int num, input bit disturb, output logic [7:0] sig_obs);
        int lf, m;
        SEED    = seed;
        NUM_PAT = CNT_W'(num);
        START   = 1'b1;
        @(negedge CK);
        START = 1'b0;
        lf = (seed == 5'd0) ? 1 : int'(seed);
        m  = 0;
        for (int i = 0; i < num; i++) begin
            check("run_pat", 32'(PAT), 32'(lf));
            check("run_vld_busy_done", {29'd0, PAT_VALID, BUSY, DONE}, 32'b110);
            m  = misr_step(m, int'(c17(5'(lf))));
            lf = lfsr_step(lf);
            if (disturb && i < num - 1) begin
                SEED    = 5'($urandom);
                NUM_PAT = CNT_W'($urandom);
                START   = 1'($urandom_range(0, 1));
            end else begin
                START = 1'b0;
            end
            @(negedge CK);
        end
        check("done_flags", {29'd0, PAT_VALID, BUSY, DONE}, 32'b001);
        check("done_pat", 32'(PAT), 32'd0);
        check("done_sig", 32'(SIG), 32'(m));
        sig_obs = SIG;
    endtask

    logic [7:0] sig_a, sig_b;

    initial begin
        RST = 1'b1; START = 1'b0; SEED = 5'd0; NUM_PAT = '0;
        #12;
        check("reset_outs", {16'd0, 3'd0, PAT, PAT_VALID, SIG, BUSY, DONE}, 32'd0);
        @(negedge CK);
        RST = 1'b0;
        repeat (2) @(negedge CK);
        check("idle_after_reset", {3'd0, PAT, PAT_VALID, SIG, BUSY, DONE, 14'd0}, 32'd0);

        // basic run with the fixed values
        do_run(5'b00001, 3, 1'b0, sig_a);
        check("basic_sig_const", 32'(sig_a), 32'h04);

        // zero seed
        do_run(5'b00000, 1, 1'b0, sig_a);
        check("zero_seed_sig_const", 32'(sig_a), 32'h01);

        // zero count: DONE on the next edge, never BUSY
        vld_cnt = 0;
        do_run(5'd7, 0, 1'b0, sig_a);
        check("zero_cnt_no_valid", 32'(vld_cnt), 32'd0);

        // reset mid-run, then reproduce the signature
        do_run(5'd9, 6, 1'b0, sig_a);
        SEED = 5'd9; NUM_PAT = CNT_W'(6); START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        @(negedge CK);
        #2 RST = 1'b1;
        #1 check("async_reset_outs", {19'd0, PAT, PAT_VALID, SIG, BUSY, DONE}, 32'd0);
        @(negedge CK);
        RST = 1'b0;
        repeat (2) @(negedge CK);
        check("idle_hold", {29'd0, PAT_VALID, BUSY, DONE}, 32'd0);
        do_run(5'd9, 6, 1'b0, sig_b);
        check("rerun_sig", 32'(sig_b), 32'(sig_a));

        // START / SEED / NUM_PAT changes ignored during RUN
        vld_cnt = 0;
        do_run(5'd21, 5, 1'b1, sig_a);
        repeat (3) @(negedge CK);
        check("start_ignored_vld", 32'(vld_cnt), 32'd5);

        // full period
        seen = 32'd0; dup_cnt = 0;
        do_run(5'b00001, 31, 1'b0, sig_a);
        check("full_period_seen", seen, 32'hFFFF_FFFE);
        check("full_period_dup", 32'(dup_cnt), 32'd0);

        // START held high restarts on the edge after DONE
        SEED = 5'd3; NUM_PAT = CNT_W'(2); START = 1'b1;
        repeat (3) @(negedge CK);
        check("held_done", {31'd0, DONE}, 32'd1);
        @(negedge CK);
        check("held_restart", {26'd0, BUSY, PAT}, {26'd0, 1'b1, 5'd3});
        START = 1'b0;
        repeat (3) @(negedge CK);
        check("held_end_done", {31'd0, DONE}, 32'd1);

        // randomized runs, including wrap (NUM_PAT > 31) and disturbance
        for (int k = 0; k < 10; k++) begin
            do_run(5'($urandom), $urandom_range(0, 63), 1'($urandom_range(0, 1)), sig_a);
            repeat ($urandom_range(0, 2)) @(negedge CK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c17_bist_driver.md
C17_BIST_DRIVER -- requirements
Module: c17_bist_driver

Interface
REQ-001 Parameter MISR_W, default 8, is the signature register width; only the value 8 is supported.
REQ-002 Parameter CNT_W, default 6, is the width of the pattern-count input and of the internal down-counter.
REQ-003 CK  input  1  is the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  is the reset: asynchronous, active-high.
REQ-005 START  input  1  is the run request, sampled in IDLE and DONE only.
REQ-006 SEED  input  5  is the initial LFSR value, captured on an accepted START.
REQ-007 NUM_PAT  input  CNT_W  is the number of patterns to apply, captured on an accepted START.
REQ-008 PAT  output  5  is the registered pattern bus: bit4 drives N1, bit3 N2, bit2 N3, bit1 N6, bit0 N7 of the c17 stage.
REQ-009 PAT_VALID  output  1  is high while PAT carries a pattern under test.
REQ-010 RESP  input  2  is the c17 response: bit1 is N22, bit0 is N23; it is combinational from PAT within the same cycle.
REQ-011 SIG  output  MISR_W  is the MISR signature.
REQ-012 BUSY  output  1  is high in RUN.
REQ-013 DONE  output  1  is high in DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE with START=1 and NUM_PAT!=0, the block SHALL, at the edge:
- load the LFSR with SEED, or with 5'b00001 if SEED==0;
- load the counter with NUM_PAT;
- clear the MISR to 0;
- enter RUN.
REQ-016 In IDLE or DONE with START=1 and NUM_PAT==0, the block SHALL clear the MISR and enter DONE without entering RUN.
REQ-017 In RUN, PAT SHALL equal the LFSR state, PAT_VALID=1 and BUSY=1.
REQ-018 The LFSR update SHALL be next = {q[3:0], q[4]^q[2]} (x^5+x^3+1, period 31); it wraps through the same 31 states when NUM_PAT>31.
REQ-019 On each RUN edge, the MISR SHALL update as m_next = {m[6:0], m[7]^m[5]^m[4]^m[3]} XOR {6'b0, RESP}, where RESP is sampled at that edge.
REQ-020 On each RUN edge, the LFSR SHALL advance and the counter SHALL decrement.
REQ-021 The RUN edge with counter==1 SHALL perform its final MISR capture and then enter DONE, so exactly NUM_PAT patterns are compacted.
REQ-022 Latency from START accepted to DONE high SHALL be NUM_PAT+1 edges.
REQ-023 START SHALL be ignored in RUN.
REQ-024 Outside RUN, PAT SHALL be 0 and PAT_VALID=0.
REQ-025 In DONE, SIG SHALL hold its value until the next accepted START or RST.
REQ-026 START held continuously high SHALL restart a run on the edge after DONE is reached.
REQ-027 SEED and NUM_PAT changes during RUN SHALL have no effect on the current run.

Reset
REQ-028 RST=1 SHALL asynchronously force, in any state including mid-RUN:
- state=IDLE;
- LFSR=5'b00001, counter=0, MISR=0;
- PAT=0, PAT_VALID=0, SIG=0, BUSY=0, DONE=0.
REQ-029 After RST deasserts, the block SHALL remain in IDLE until START=1 is sampled.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Basic run: SEED=5'b00001, NUM_PAT=3, c17 connected -> PAT sequence 00001, 00010, 00100; RESP 01, 00, 00; SIG=8'h04; DONE high 4 edges after START.
- Zero seed: SEED=0, NUM_PAT=1 -> PAT=00001, SIG=8'h01.
- Zero count: NUM_PAT=0, START pulse -> DONE next edge, BUSY never high, SIG=0.
- Reset mid-operation: RST asserted mid-RUN after 2 patterns -> all outputs 0 immediately, without waiting for CK; START then reruns from SEED and reproduces the first signature.
- START ignored in RUN: START pulses during RUN with NUM_PAT=5 -> exactly 5 PAT_VALID cycles.
- Full period: NUM_PAT=31, SEED=5'b00001 -> all 31 nonzero PAT values seen once, no duplicates.
